// File: rtl/l2_arbiter.sv
// l2_arbiter
// Second-level fill engine sitting between two L1 cache clients and a
// backing word memory. Port 0 (icache) has fixed priority over port 1
// (dcache). The winner owns the engine for a whole page: PAGE_WORDS
// 16-bit words are read one at a time from backing memory and handed to
// the owner as single-cycle ready pulses on the shared l2_data bus.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   l2_start0/1              fill request from client 0 / 1
//   l2_page0/1   [WIDTH]     page number of the requested fill
//   l2_write0/1              reserved, ignored (every fill is a read)
//   l2_busy                  a transaction is in progress
//   l2_launch0/1             grant, high for the whole owned transaction
//   l2_ready0/1              one-cycle pulse, l2_data holds the next word
//   l2_data      [16]        shared fill data
//   mem_req                  backing-memory read request
//   mem_addr     [MEM_AW]    backing-memory word address
//   mem_valid                read data valid (only looked at in REQ)
//   mem_rdata    [16]        backing-memory read data

module l2_arbiter #(
    parameter int WIDTH      = 32,
    parameter int PAGE_BYTES = 32,
    parameter int MEM_AW     = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l2_start0,
    input  logic              l2_start1,
    input  logic [WIDTH-1:0]  l2_page0,
    input  logic [WIDTH-1:0]  l2_page1,
    input  logic              l2_write0,
    input  logic              l2_write1,
    output logic              l2_busy,
    output logic              l2_launch0,
    output logic              l2_launch1,
    output logic              l2_ready0,
    output logic              l2_ready1,
    output logic [15:0]       l2_data,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [15:0]       mem_rdata
);

    localparam int PAGE_WORDS = PAGE_BYTES / 2;
    localparam int IDX_W      = $clog2(PAGE_WORDS);
    // Only the page bits that survive truncation into mem_addr are kept.
    localparam int PAGE_KEEP  = MEM_AW - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAGE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DELIVER
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 owner;
    logic [IDX_W-1:0]     idx;
    logic [PAGE_KEEP-1:0] page;

    // Inputs that have no effect on the engine: the write flags and the
    // page bits that would fall off the top of the memory address.
    logic unused_inputs;
    assign unused_inputs = ^{l2_write0, l2_write1,
                             l2_page0[WIDTH-1:PAGE_KEEP],
                             l2_page1[WIDTH-1:PAGE_KEEP]};

    // The address is built straight from the latched page and word index,
    // so it cannot move while a read is outstanding.
    assign mem_addr = {page, idx};

    // State register. Reset returns the engine to IDLE immediately, which
    // drops every state-decoded output without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode. Starts are only looked at in IDLE, so
    // an owner that keeps its start high, or a loser that keeps polling,
    // can never disturb a running transaction. Ready is a pure decode of
    // DELIVER, which is exactly one cycle long per word.
    always_comb begin
        next_state = state;
        l2_busy    = 1'b0;
        l2_launch0 = 1'b0;
        l2_launch1 = 1'b0;
        l2_ready0  = 1'b0;
        l2_ready1  = 1'b0;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                if (l2_start0 || l2_start1) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                l2_busy    = 1'b1;
                l2_launch0 = ~owner;
                l2_launch1 = owner;
                mem_req    = 1'b1;
                if (mem_valid) begin
                    next_state = DELIVER;
                end
            end
            DELIVER: begin
                l2_busy    = 1'b1;
                l2_launch0 = ~owner;
                l2_launch1 = owner;
                l2_ready0  = ~owner;
                l2_ready1  = owner;
                next_state = (idx == LAST_IDX) ? IDLE : REQ;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Transaction datapath: owner, page and index are captured at grant,
    // read data is captured when memory answers, and the index advances
    // after each delivered word. l2_data keeps its value between captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner   <= 1'b0;
            idx     <= '0;
            page    <= '0;
            l2_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (l2_start0) begin
                        owner <= 1'b0;
                        page  <= l2_page0[PAGE_KEEP-1:0];
                        idx   <= '0;
                    end else if (l2_start1) begin
                        owner <= 1'b1;
                        page  <= l2_page1[PAGE_KEEP-1:0];
                        idx   <= '0;
                    end
                end
                REQ: begin
                    if (mem_valid) begin
                        l2_data <= mem_rdata;
                    end
                end
                DELIVER: begin
                    if (idx != LAST_IDX) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter
// Directed bench for l2_arbiter. A behavioural backing memory answers
// reads with a fixed function of the address after a configurable number
// of wait cycles; every step of a fill is checked cycle by cycle against
// the timing the engine is expected to follow.

module tb_l2_arbiter;

    logic        clk;
    logic        rst;
    logic        l2_start0;
    logic        l2_start1;
    logic [31:0] l2_page0;
    logic [31:0] l2_page1;
    logic        l2_write0;
    logic        l2_write1;
    logic        l2_busy;
    logic        l2_launch0;
    logic        l2_launch1;
    logic        l2_ready0;
    logic        l2_ready1;
    logic [15:0] l2_data;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_valid;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int wait_cfg = 0;
    int wait_cnt = 0;

    l2_arbiter #(
        .WIDTH(32),
        .PAGE_BYTES(32),
        .MEM_AW(24)
    ) dut (
        .clk(clk),
        .rst(rst),
        .l2_start0(l2_start0),
        .l2_start1(l2_start1),
        .l2_page0(l2_page0),
        .l2_page1(l2_page1),
        .l2_write0(l2_write0),
        .l2_write1(l2_write1),
        .l2_busy(l2_busy),
        .l2_launch0(l2_launch0),
        .l2_launch1(l2_launch1),
        .l2_ready0(l2_ready0),
        .l2_ready1(l2_ready1),
        .l2_data(l2_data),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_valid(mem_valid),
        .mem_rdata(mem_rdata)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [15:0] memWord(input logic [23:0] a);
        logic [7:0] hi;
        hi = a[23:16];
        return a[15:0] ^ 16'hC35A ^ {hi, hi};
    endfunction

    assign mem_rdata = memWord(mem_addr);
    assign mem_valid = mem_req && (wait_cnt == wait_cfg);

    // Counts wait cycles of the current read; restarts once a read is
    // answered or the request goes away.
    always @(posedge clk) begin
        if (!mem_req || mem_valid) begin
            wait_cnt <= 0;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s0, input logic s1,
                                 input logic [31:0] p0, input logic [31:0] p1);
        l2_start0 = s0;
        l2_start1 = s1;
        l2_page0  = p0;
        l2_page1  = p1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks one fill from its first REQ cycle. Each word spends waits+1
    // cycles in REQ and one cycle in DELIVER. The owner drops its start
    // once the first word has been delivered. A full page ends in the
    // first IDLE cycle after the transaction.
    task automatic fillExpect(input int port, input logic [31:0] page,
                              input int waits, input int nwords);
        logic [23:0] addr;
        logic        own_launch;
        logic        oth_launch;
        logic        own_ready;
        logic        oth_ready;
        for (int k = 0; k < nwords; k++) begin
            addr = 24'({page, 4'(k)});
            for (int w = 0; w <= waits; w++) begin
                own_launch = (port == 0) ? l2_launch0 : l2_launch1;
                oth_launch = (port == 0) ? l2_launch1 : l2_launch0;
                own_ready  = (port == 0) ? l2_ready0 : l2_ready1;
                oth_ready  = (port == 0) ? l2_ready1 : l2_ready0;
                checkOutput($sformatf("p%0d w%0d busy", port, k), 32'(l2_busy), 32'd1);
                checkOutput($sformatf("p%0d w%0d launch", port, k), 32'(own_launch), 32'd1);
                checkOutput($sformatf("p%0d w%0d other_launch", port, k), 32'(oth_launch), 32'd0);
                checkOutput($sformatf("p%0d w%0d mem_req", port, k), 32'(mem_req), 32'd1);
                checkOutput($sformatf("p%0d w%0d mem_addr", port, k), 32'(mem_addr), 32'(addr));
                checkOutput($sformatf("p%0d w%0d early_ready", port, k), 32'(own_ready), 32'd0);
                checkOutput($sformatf("p%0d w%0d other_ready", port, k), 32'(oth_ready), 32'd0);
                tick();
            end
            own_launch = (port == 0) ? l2_launch0 : l2_launch1;
            oth_launch = (port == 0) ? l2_launch1 : l2_launch0;
            own_ready  = (port == 0) ? l2_ready0 : l2_ready1;
            oth_ready  = (port == 0) ? l2_ready1 : l2_ready0;
            checkOutput($sformatf("p%0d w%0d ready", port, k), 32'(own_ready), 32'd1);
            checkOutput($sformatf("p%0d w%0d deliver_other_ready", port, k), 32'(oth_ready), 32'd0);
            checkOutput($sformatf("p%0d w%0d deliver_launch", port, k), 32'(own_launch), 32'd1);
            checkOutput($sformatf("p%0d w%0d deliver_other_launch", port, k), 32'(oth_launch), 32'd0);
            checkOutput($sformatf("p%0d w%0d data", port, k), 32'(l2_data), 32'(memWord(addr)));
            checkOutput($sformatf("p%0d w%0d deliver_mem_req", port, k), 32'(mem_req), 32'd0);
            if (k == 0) begin
                if (port == 0) l2_start0 = 1'b0;
                else           l2_start1 = 1'b0;
            end
            tick();
        end
        if (nwords == 16) begin
            checkOutput($sformatf("p%0d end busy", port), 32'(l2_busy), 32'd0);
            checkOutput($sformatf("p%0d end launch0", port), 32'(l2_launch0), 32'd0);
            checkOutput($sformatf("p%0d end launch1", port), 32'(l2_launch1), 32'd0);
            checkOutput($sformatf("p%0d end mem_req", port), 32'(mem_req), 32'd0);
        end
    endtask

    // Directed sequence.
    initial begin
        rst = 1'b1;
        l2_write0 = 1'b0;
        l2_write1 = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        checkOutput("reset busy", 32'(l2_busy), 32'd0);
        checkOutput("reset launch0", 32'(l2_launch0), 32'd0);
        checkOutput("reset launch1", 32'(l2_launch1), 32'd0);
        checkOutput("reset ready0", 32'(l2_ready0), 32'd0);
        checkOutput("reset ready1", 32'(l2_ready1), 32'd0);
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset data", 32'(l2_data), 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("idle busy", 32'(l2_busy), 32'd0);

        $display("[TB] single port-1 fill, page 0x123, zero wait");
        l2_write1 = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h123);
        tick();
        fillExpect(1, 32'h123, 0, 16);
        l2_write1 = 1'b0;

        $display("[TB] simultaneous starts, port 0 page 5, port 1 page 9");
        applyStimulus(1'b1, 1'b1, 32'h5, 32'h9);
        tick();
        fillExpect(0, 32'h5, 0, 16);
        tick();
        fillExpect(1, 32'h9, 0, 16);

        $display("[TB] three wait cycles per word");
        wait_cfg = 3;
        applyStimulus(1'b1, 1'b0, 32'h0A0, 32'h0);
        tick();
        fillExpect(0, 32'h0A0, 3, 16);
        wait_cfg = 0;

        $display("[TB] page change after grant, owner start held through word 0");
        applyStimulus(1'b1, 1'b0, 32'h42, 32'h0);
        tick();
        l2_page0 = 32'h77;
        fillExpect(0, 32'h42, 0, 16);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("no regrant busy c%0d", i), 32'(l2_busy), 32'd0);
            checkOutput($sformatf("no regrant launch0 c%0d", i), 32'(l2_launch0), 32'd0);
        end

        $display("[TB] reset during word 6");
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h55);
        tick();
        fillExpect(1, 32'h55, 0, 6);
        checkOutput("pre-reset mem_req", 32'(mem_req), 32'd1);
        checkOutput("pre-reset mem_addr", 32'(mem_addr), 32'h000556);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst busy", 32'(l2_busy), 32'd0);
        checkOutput("async rst launch1", 32'(l2_launch1), 32'd0);
        checkOutput("async rst ready1", 32'(l2_ready1), 32'd0);
        checkOutput("async rst mem_req", 32'(mem_req), 32'd0);
        checkOutput("async rst mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("async rst data", 32'(l2_data), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post-reset busy", 32'(l2_busy), 32'd0);
        checkOutput("post-reset ready1", 32'(l2_ready1), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h66, 32'h0);
        tick();
        fillExpect(0, 32'h66, 0, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
